// File: rtl/morse_tx.sv
// Morse transmitter: snapshots an eight-slot text buffer and keys it out as ITU Morse.
// Optional buzzer tone generator enabled by defining MORSE_TX_TONE_EN.
module morse_tx #(
  parameter int unsigned UNIT_CYCLES = 5_000_000,
  parameter int unsigned TONE_HALF   = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] text,
  output logic        key,
  output logic        tone,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_1U = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_3U = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_4U = CNT_W'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ON, S_EGAP, S_CGAP, S_WGAP, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [63:0]      text_q, text_d;
  logic [4:0]       pat_q, pat_d;
  logic [2:0]       rem_q, rem_d;
  logic             key_q, busy_q, done_q;
  logic             key_d, busy_d, done_d;
  logic             adv;
  logic [7:0]       slot_byte;
  logic [7:0]       code;

  // Returns {length, pattern}; pattern is left-aligned, first element in bit 4, 1 = dash.
  function automatic logic [7:0] morse_lut(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
    case (u)
      8'h41: morse_lut = {3'd2, 5'b01000};  // A
      8'h42: morse_lut = {3'd4, 5'b10000};
      8'h43: morse_lut = {3'd4, 5'b10100};
      8'h44: morse_lut = {3'd3, 5'b10000};
      8'h45: morse_lut = {3'd1, 5'b00000};
      8'h46: morse_lut = {3'd4, 5'b00100};
      8'h47: morse_lut = {3'd3, 5'b11000};
      8'h48: morse_lut = {3'd4, 5'b00000};
      8'h49: morse_lut = {3'd2, 5'b00000};
      8'h4A: morse_lut = {3'd4, 5'b01110};
      8'h4B: morse_lut = {3'd3, 5'b10100};
      8'h4C: morse_lut = {3'd4, 5'b01000};
      8'h4D: morse_lut = {3'd2, 5'b11000};
      8'h4E: morse_lut = {3'd2, 5'b10000};
      8'h4F: morse_lut = {3'd3, 5'b11100};
      8'h50: morse_lut = {3'd4, 5'b01100};
      8'h51: morse_lut = {3'd4, 5'b11010};
      8'h52: morse_lut = {3'd3, 5'b01000};
      8'h53: morse_lut = {3'd3, 5'b00000};
      8'h54: morse_lut = {3'd1, 5'b10000};
      8'h55: morse_lut = {3'd3, 5'b00100};
      8'h56: morse_lut = {3'd4, 5'b00010};
      8'h57: morse_lut = {3'd3, 5'b01100};
      8'h58: morse_lut = {3'd4, 5'b10010};
      8'h59: morse_lut = {3'd4, 5'b10110};
      8'h5A: morse_lut = {3'd4, 5'b11000};
      8'h30: morse_lut = {3'd5, 5'b11111};  // 0
      8'h31: morse_lut = {3'd5, 5'b01111};
      8'h32: morse_lut = {3'd5, 5'b00111};
      8'h33: morse_lut = {3'd5, 5'b00011};
      8'h34: morse_lut = {3'd5, 5'b00001};
      8'h35: morse_lut = {3'd5, 5'b00000};
      8'h36: morse_lut = {3'd5, 5'b10000};
      8'h37: morse_lut = {3'd5, 5'b11000};
      8'h38: morse_lut = {3'd5, 5'b11100};
      8'h39: morse_lut = {3'd5, 5'b11110};
      default: morse_lut = 8'h00;           // length 0 marks a word space
    endcase
  endfunction

  // Slot k lives at text[63-8k -: 8]; its low bit index 8*(7-k) is {~k, 3'b000}.
  assign slot_byte = text_q[{~idx_q, 3'b000} +: 8];
  assign code      = morse_lut(slot_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      text_q  <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      text_q  <= text_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    text_d  = text_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          text_d  = text;
          idx_d   = 3'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (slot_byte == 8'hFF) begin
          adv = 1'b1;
        end else if (code[7:5] != 3'd0) begin
          rem_d   = code[7:5];
          pat_d   = code[4:0];
          state_d = S_ON;
        end else begin
          state_d = S_WGAP;
        end
      end
      S_ON: begin
        if (cnt_q == (pat_q[4] ? CNT_3U : CNT_1U)) begin
          if (rem_q > 3'd1) begin
            rem_d   = rem_q - 3'd1;
            pat_d   = {pat_q[3:0], 1'b0};
            state_d = S_EGAP;
          end else begin
            state_d = S_CGAP;
          end
        end
      end
      S_EGAP: if (cnt_q == CNT_1U) state_d = S_ON;
      S_CGAP: if (cnt_q == CNT_3U) adv = 1'b1;
      S_WGAP: if (cnt_q == CNT_4U) adv = 1'b1;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Moving past slot 7 ends the transmission.
    if (adv) begin
      if (idx_q == 3'd7) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = S_SCAN;
      end
    end

    if (abort && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;

    if (state_d != state_q) cnt_d = '0;

    key_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef MORSE_TX_TONE_EN
  localparam int unsigned TW = $clog2(TONE_HALF + 1);

  logic [TW-1:0] tcnt_q;
  logic          tone_q;

  // Tone restarts low at the beginning of every key-high run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      tone_q <= 1'b0;
    end else if (key_d && key_q) begin
      if (tcnt_q == TW'(TONE_HALF - 1)) begin
        tcnt_q <= '0;
        tone_q <= ~tone_q;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end else begin
      tcnt_q <= '0;
      tone_q <= 1'b0;
    end
  end

  assign tone = tone_q;
`else
  assign tone = 1'b0;
`endif

endmodule
